shift_arbiter: RTL and testbench

- Shares one 32-bit barrel shifter (logical left, logical right, arithmetic right; 5-bit shift amount) among NREQ requesters.
- Selects one requester per cycle by round-robin and registers the shifted result with the winner's ID.
- Presents the result on a valid/ready response port.
- Sits between multi-issue execution slots and the single shift datapath of the CPU core.

---
 rtl/shift_arbiter.sv | 131 +++++++++++++
 tb/tb_shift_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter among NREQ requesters,
// with a single registered valid/ready response slot and a saturating completion counter.
module shift_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_d,
  input  logic [NREQ*5-1:0]  req_sa,
  input  logic [NREQ-1:0]    req_right,
  input  logic [NREQ-1:0]    req_arith,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [31:0]        resp_data,
  output logic [IDW-1:0]     resp_id,
  output logic [CNTW-1:0]    op_count
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            can_accept;
  logic            grant_found;
  logic            fire;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  idx;
  logic [31:0]     sel_d;
  logic [4:0]      sel_sa;
  logic            sel_right;
  logic            sel_arith;
  logic [31:0]     shifted;

  assign can_accept = (state_q == EMPTY) || resp_ready;
  assign fire       = can_accept && grant_found;

  // IDW-bit index arithmetic wraps modulo NREQ because NREQ is a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    req_ready   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ptr_q + k[IDW-1:0];
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    if (can_accept && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_d     = '0;
    sel_sa    = '0;
    sel_right = 1'b0;
    sel_arith = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == i[IDW-1:0]) begin
        sel_d     = req_d[i*32 +: 32];
        sel_sa    = req_sa[i*5 +: 5];
        sel_right = req_right[i];
        sel_arith = req_arith[i];
      end
    end
  end

  // Arithmetic branch kept separate so the signed operand is not
  // coerced to unsigned by a mixed-sign conditional expression.
  always_comb begin
    shifted = '0;
    if (!sel_right) begin
      shifted = sel_d << sel_sa;
    end else if (sel_arith) begin
      shifted = $signed(sel_d) >>> sel_sa;
    end else begin
      shifted = sel_d >> sel_sa;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (fire) begin
      state_d = FULL;
      data_d  = shifted;
      id_d    = grant_idx;
      ptr_d   = grant_idx + IDW'(1);
    end else if ((state_q == FULL) && resp_ready) begin
      state_d = EMPTY;
    end
    if ((state_q == FULL) && resp_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_valid = (state_q == FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus a queue scoreboard that
// predicts every response from a bitwise reference shifter.
module tb_shift_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 16;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_d;
  logic [NREQ*5-1:0]  req_sa;
  logic [NREQ-1:0]    req_right;
  logic [NREQ-1:0]    req_arith;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic [IDW-1:0]     resp_id;
  logic [CNTW-1:0]    op_count;

  int total;
  int bad;
  logic [IDW+31:0] sbq[$];

  shift_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_d(req_d), .req_sa(req_sa), .req_right(req_right), .req_arith(req_arith),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .op_count(op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sa,
                                        input logic right, input logic arith);
    logic [31:0] r;
    int src;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (!right) begin
        src = b - int'(sa);
        if (src >= 0) r[b] = d[src];
      end else begin
        src = b + int'(sa);
        if (src < 32) r[b] = d[src];
        else          r[b] = arith & d[31];
      end
    end
    return r;
  endfunction

  task automatic sb();
    logic [IDW+31:0] e;
    if (rst) begin
      sbq.delete();
      return;
    end
    total++;
    if ($countones(req_ready) > 1) begin
      bad++;
      $display("FAIL onehot: req_ready=%b has more than one bit set", req_ready);
    end
    if (resp_valid && resp_ready) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: got id=%0d data=%h, expected nothing", resp_id, resp_data);
      end else begin
        e = sbq.pop_front();
        if ({resp_id, resp_data} !== e) begin
          bad++;
          $display("FAIL sb_resp: got id=%0d data=%h, expected id=%0d data=%h",
                   resp_id, resp_data, e[IDW+31:32], e[31:0]);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sbq.push_back({IDW'(i), model(req_d[i*32 +: 32], req_sa[i*5 +: 5], req_right[i], req_arith[i])});
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic adv();
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv();
    half();
    adv();
    rst = 1'b0;
    half();
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    total++;
    if (op_count !== 16'h0000) begin bad++; $display("FAIL reset_count: got %h expected 0000", op_count); end
    adv();
  endtask

  task automatic test_single();
    req_d[31:0] = 32'h8000_0001;
    req_sa[4:0] = 5'd4;
    req_right[0] = 1'b1;
    req_arith[0] = 1'b1;
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    half();
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    adv();
    req_valid = 4'b0000;
    half();
    total++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hF800_0000 || resp_id !== 2'd0) begin
      bad++;
      $display("FAIL single_resp: got v=%b data=%h id=%0d expected v=1 data=f8000000 id=0",
               resp_valid, resp_data, resp_id);
    end
    adv();
    half();
    total++;
    if (op_count !== 16'h0001) begin bad++; $display("FAIL single_count: got %h expected 0001", op_count); end
    adv();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    half();
    adv();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_d[i*32 +: 32] = $urandom;
      req_sa[i*5 +: 5]  = 5'($urandom_range(0, 31));
      req_right[i]      = 1'($urandom_range(0, 1));
      req_arith[i]      = 1'($urandom_range(0, 1));
    end
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      half();
      total++;
      if (req_ready !== 4'(1 << (n % 4))) begin
        bad++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", n, req_ready, 4'(1 << (n % 4)));
      end
      if (n > 0) begin
        total++;
        if (resp_valid !== 1'b1 || resp_id !== 2'((n - 1) % 4)) begin
          bad++;
          $display("FAIL rr_id[%0d]: got v=%b id=%0d expected v=1 id=%0d", n, resp_valid, resp_id, (n - 1) % 4);
        end
      end
      adv();
    end
    req_valid = 4'b0000;
    half();
    total++;
    if (resp_id !== 2'd0) begin bad++; $display("FAIL rr_last_id: got %0d expected 0", resp_id); end
    adv();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp1;
    exp1 = model(req_d[63:32], req_sa[9:5], req_right[1], req_arith[1]);
    req_valid = 4'b1111;
    resp_ready = 1'b0;
    half();
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_first: got %b expected 0010", req_ready); end
    adv();
    for (int c = 0; c < 3; c++) begin
      half();
      total++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== exp1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d data=%h expected rdy=0000 v=1 id=1 data=%h",
                 c, req_ready, resp_valid, resp_id, resp_data, exp1);
      end
      adv();
    end
    resp_ready = 1'b1;
    half();
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_release: got %b expected 0100", req_ready); end
    adv();
    req_valid = 4'b0000;
    half();
    total++;
    if (resp_id !== 2'd2) begin bad++; $display("FAIL bp_next_id: got %0d expected 2", resp_id); end
    adv();
  endtask

  task automatic test_shift_modes();
    logic [4:0]  sa_t[4]    = '{5'd0, 5'd31, 5'd31, 5'd31};
    logic        right_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic        arith_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t[4]   = '{32'hF000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    resp_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      req_d[95:64]   = 32'hF000_0000;
      req_sa[14:10]  = sa_t[m];
      req_right[2]   = right_t[m];
      req_arith[2]   = arith_t[m];
      req_valid      = 4'b0100;
      half();
      total++;
      if (req_ready !== 4'b0100) begin bad++; $display("FAIL mode_ready[%0d]: got %b expected 0100", m, req_ready); end
      adv();
      req_valid = 4'b0000;
      half();
      total++;
      if (resp_valid !== 1'b1 || resp_data !== exp_t[m] || resp_id !== 2'd2) begin
        bad++;
        $display("FAIL mode_data[%0d]: got v=%b data=%h id=%0d expected v=1 data=%h id=2",
                 m, resp_valid, resp_data, resp_id, exp_t[m]);
      end
      adv();
    end
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    half();
    adv();
    req_valid = 4'b0000;
    half();
    total++;
    if (resp_valid !== 1'b1) begin bad++; $display("FAIL midop_full: got %b expected 1", resp_valid); end
    rst = 1'b1;
    adv();
    rst = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    half();
    total++;
    if (resp_valid !== 1'b0 || op_count !== 16'h0000) begin
      bad++;
      $display("FAIL midop_cleared: got v=%b cnt=%h expected v=0 cnt=0000", resp_valid, op_count);
    end
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL midop_ptr: got %b expected 0001", req_ready); end
    adv();
    req_valid = 4'b0000;
    half();
    adv();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    half();
    adv();
    rst = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      half();
      if (i == 65535) begin
        total++;
        if (op_count !== 16'hFFFE) begin bad++; $display("FAIL sat_before: got %h expected fffe", op_count); end
      end
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      half();
      total++;
      if (op_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold[%0d]: got %h expected ffff", c, op_count); end
      adv();
    end
    req_valid = 4'b0000;
    half();
    adv();
    half();
    adv();
    total++;
    if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size()); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    req_valid = '0;
    req_d = '0;
    req_sa = '0;
    req_right = '0;
    req_arith = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_shift_modes();
    test_reset_midop();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
